i2c_cfg_sequencer: RTL and testbench
====================================

// Module: i2c_cfg_sequencer
// PURPOSE
//  Walks an external combinational sensor-config LUT ({reg_addr, reg_data} entries) and issues
//  one register write per entry to an I2C master through a req/done handshake. Successor to the
//  fixed 16/8-bit tables: parametrised widths, selectable profile banks, in-table delay entries,
//  NACK retry and error reporting. Sits between the sensor LUTs and the I2C byte engine.
// PARAMETERS
//  ADDR_W      16          register address width carried in each LUT entry
//  DATA_W      8           register data width carried in each LUT entry
//  IDX_W       9           LUT index width (max entries per profile = 2**IDX_W)
//  PROF_W      2           profile select width (2**PROF_W LUT banks)
//  CLK_FREQ    50_000_000  clk frequency in Hz; one delay unit = CLK_FREQ/1000 cycles (1 ms)
//  RETRY_MAX   3           extra attempts per entry after a NACK before aborting
//  DELAY_ADDR  16'hFFFF    entry address marking a delay entry; data field = delay in ms
// PORTS
//  clk          in   1                  system clock, all logic on rising edge
//  rst          in   1                  asynchronous active-high reset
//  start        in   1                  one-cycle pulse: begin sequence; ignored while busy
//  profile_sel  in   PROF_W             profile bank, captured on accepted start
//  lut_profile  out  PROF_W             registered profile driven to LUT bank mux
//  lut_index    out  IDX_W              registered entry index driven to LUT
//  lut_data     in   ADDR_W+DATA_W      {addr, data} returned combinationally by LUT
//  lut_size     in   IDX_W+1            entry count of selected profile, valid with lut_profile
//  i2c_req      out  1                  write request, held until i2c_done
//  i2c_addr     out  ADDR_W             register address, stable while i2c_req
//  i2c_wdata    out  DATA_W             register data, stable while i2c_req
//  i2c_done     in   1                  one-cycle pulse: transaction finished
//  i2c_nack     in   1                  sampled only when i2c_done=1; 1 = slave NACKed
//  busy         out  1                  high from accepted start until DONE/ERROR
//  done         out  1                  level, high after full table written; cleared by start
//  error        out  1                  level, high after retry exhaustion; cleared by start
//  err_index    out  IDX_W              index of failing entry, valid while error=1
// BEHAVIOUR
//  Reset: state IDLE; lut_index=0, lut_profile=0, i2c_req=0, i2c_addr=0, i2c_wdata=0,
//   busy=0, done=0, error=0, err_index=0, retry and delay counters 0. Reset mid-transfer
//   drops i2c_req immediately (async); the I2C master must tolerate abandoned requests.
//  IDLE: on start -> capture profile_sel, lut_index=0, clear done/error, busy=1 -> FETCH.
//  FETCH (1 cycle): LUT settles on registered index/profile. If lut_index >= lut_size -> DONE
//   (lut_size=0 gives DONE with zero writes). Else register lut_data -> DECODE.
//  DECODE: addr==DELAY_ADDR -> DELAY with count = data*(CLK_FREQ/1000); data=0 -> NEXT
//   directly. Otherwise drive i2c_addr/i2c_wdata, i2c_req=1, retry_cnt=0 -> WAIT_ACK.
//  WAIT_ACK: hold req/addr/wdata. On i2c_done: req=0 same edge; nack=0 -> NEXT;
//   nack=1 and retry_cnt<RETRY_MAX -> retry_cnt++, reissue same entry next cycle (req=1);
//   nack=1 and retry_cnt==RETRY_MAX -> err_index=lut_index -> ERROR.
//  DELAY: count down to 1 then NEXT; total DELAY dwell = data ms exactly (in clk cycles).
//  NEXT: lut_index++ -> FETCH. Index never wraps: lut_size bounds it (IDX_W+1-bit compare).
//  DONE: done=1, busy=0 -> IDLE.  ERROR: error=1, busy=0 -> IDLE. Both levels held.
//  start while busy ignored; start in same cycle as DONE/ERROR entry ignored (busy still 1).
//  Per-write overhead excluding I2C time: FETCH+DECODE = 2 cycles before i2c_req rises.
//  i2c_done without i2c_req (spurious) ignored outside WAIT_ACK.
//  Delay counter width sized for (2**DATA_W-1)*(CLK_FREQ/1000).
// TESTING (CLK_FREQ=1000 so 1 ms = 1 cycle; I2C model acks after 5 cycles)
//  3-entry profile {0x0103,01},{0x0100,00},{0x3039,d3}, start -> 3 writes in order, addr/data
//   exact, done=1, busy=0, error=0.
//  Entry {DELAY_ADDR,0x0A} between two writes -> gap of 10 cycles DELAY + FETCH/DECODE overhead
//   between first i2c_done and second i2c_req; delay data 0 -> no DELAY dwell.
//  Model NACKs entry 1 twice then ACKs -> 3 requests for entry 1, sequence completes, done=1.
//  Model NACKs entry 2 always (RETRY_MAX=3) -> 4 requests, error=1, err_index=2, no entry 3 write.
//  profile_sel=1 with lut_size=0 -> done=1 two cycles after start, i2c_req never asserted;
//   start pulses during busy -> no restart, no index reset.
//  Assert rst while i2c_req=1 mid-table -> all outputs at reset values same cycle; new start
//   replays from index 0.

Source files
------------

// File: rtl/i2c_cfg_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_cfg_sequencer_if                                         |
// | Description : Register-write handshake between the config sequencer and    |
// |               the I2C byte engine.                                         |
// |               master : req, addr, wdata out / done, nack in (sequencer)    |
// |               slave  : req, addr, wdata in  / done, nack out (I2C engine)  |
// |   req    1       write request, held until done                            |
// |   addr   ADDR_W  register address, stable while req                       |
// |   wdata  DATA_W  register data, stable while req                          |
// |   done   1       one-cycle pulse, transaction finished                     |
// |   nack   1       valid with done, 1 = slave NACKed                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface i2c_cfg_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) ();
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              done;
   logic              nack;

   modport master (output req, output addr, output wdata, input done, input nack);
   modport slave  (input req, input addr, input wdata, output done, output nack);
endinterface
`default_nettype wire

// File: rtl/i2c_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_cfg_sequencer                                            |
// | Description : Walks an external combinational {reg_addr, reg_data} LUT     |
// |               and issues one I2C register write per entry. Supports        |
// |               profile banks, in-table millisecond delays, NACK retry and   |
// |               error reporting.                                             |
// | Ports       : clk, rst (async, active high)                                |
// |               start/profile_sel  : sequence launch and bank select         |
// |               lut_profile/lut_index -> LUT, lut_data/lut_size <- LUT       |
// |               i2c (master modport): req/addr/wdata out, done/nack in       |
// |               busy/done/error/err_index : status                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module i2c_cfg_sequencer #(
   parameter int              ADDR_W     = 16,
   parameter int              DATA_W     = 8,
   parameter int              IDX_W      = 9,
   parameter int              PROF_W     = 2,
   parameter int              CLK_FREQ   = 50_000_000,
   parameter int              RETRY_MAX  = 3,
   parameter logic [ADDR_W-1:0] DELAY_ADDR = 16'hFFFF
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     start,
   input  wire logic [PROF_W-1:0]        profile_sel,
   output      logic [PROF_W-1:0]        lut_profile,
   output      logic [IDX_W-1:0]         lut_index,
   input  wire logic [ADDR_W+DATA_W-1:0] lut_data,
   input  wire logic [IDX_W:0]           lut_size,
   i2c_cfg_sequencer_if.master           i2c,
   output      logic                     busy,
   output      logic                     done,
   output      logic                     error,
   output      logic [IDX_W-1:0]         err_index
);

   // Cycles per millisecond; the delay counter holds the largest data*ms product.
   localparam int MS_CYC = CLK_FREQ / 1000;
   localparam int DLY_W  = DATA_W + $clog2(MS_CYC + 1);
   localparam int RTY_W  = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);

   localparam logic [DLY_W-1:0] c_ms_cyc    = DLY_W'(MS_CYC);
   localparam logic [RTY_W-1:0] c_retry_max = RTY_W'(RETRY_MAX);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_WAIT_ACK = 4'd3;
   localparam logic [3:0] S_RETRY    = 4'd4;
   localparam logic [3:0] S_DELAY    = 4'd5;
   localparam logic [3:0] S_NEXT     = 4'd6;
   localparam logic [3:0] S_DONE     = 4'd7;
   localparam logic [3:0] S_ERROR    = 4'd8;

   logic [3:0]        r_state;
   logic [3:0]        w_next_state;

   // One bit wider than the LUT index so a full 2**IDX_W table ends cleanly
   // instead of wrapping back to entry 0.
   logic [IDX_W:0]    r_idx;
   logic [ADDR_W-1:0] r_ent_addr;
   logic [DATA_W-1:0] r_ent_data;
   logic [DLY_W-1:0]  r_dly_cnt;
   logic [RTY_W-1:0]  r_rty_cnt;
   logic [PROF_W-1:0] r_profile;
   logic              r_req;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic [IDX_W-1:0]  r_err_index;

   logic w_table_end;
   logic w_is_delay;
   logic w_delay_zero;
   logic w_retry_left;

   logic w_accept;
   logic w_load_entry;
   logic w_issue;
   logic w_delay_load;
   logic w_delay_dec;
   logic w_ack;
   logic w_retry;
   logic w_fail;
   logic w_reissue;
   logic w_index_inc;
   logic w_finish_ok;
   logic w_finish_err;

   assign w_table_end  = (r_idx >= lut_size);
   assign w_is_delay   = (r_ent_addr == DELAY_ADDR);
   assign w_delay_zero = (r_ent_data == '0);
   assign w_retry_left = (r_rty_cnt < c_retry_max);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:     if (start) w_next_state = S_FETCH;
         S_FETCH:    w_next_state = w_table_end ? S_DONE : S_DECODE;
         S_DECODE: begin
            if (!w_is_delay)       w_next_state = S_WAIT_ACK;
            else if (w_delay_zero) w_next_state = S_NEXT;
            else                   w_next_state = S_DELAY;
         end
         S_WAIT_ACK: begin
            // done is only honoured here, so a stray pulse elsewhere is ignored.
            if (i2c.done) begin
               if (!i2c.nack)         w_next_state = S_NEXT;
               else if (w_retry_left) w_next_state = S_RETRY;
               else                   w_next_state = S_ERROR;
            end
         end
         S_RETRY:    w_next_state = S_WAIT_ACK;
         // Counter is loaded with data*ms, so exiting on 1 gives exactly that dwell.
         S_DELAY:    if (r_dly_cnt == DLY_W'(1)) w_next_state = S_NEXT;
         S_NEXT:     w_next_state = S_FETCH;
         S_DONE:     w_next_state = S_IDLE;
         S_ERROR:    w_next_state = S_IDLE;
         default:    w_next_state = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- output decode
   always_comb begin
      w_accept     = 1'b0;
      w_load_entry = 1'b0;
      w_issue      = 1'b0;
      w_delay_load = 1'b0;
      w_delay_dec  = 1'b0;
      w_ack        = 1'b0;
      w_retry      = 1'b0;
      w_fail       = 1'b0;
      w_reissue    = 1'b0;
      w_index_inc  = 1'b0;
      w_finish_ok  = 1'b0;
      w_finish_err = 1'b0;
      case (r_state)
         S_IDLE:     w_accept     = start;
         S_FETCH:    w_load_entry = !w_table_end;
         S_DECODE: begin
            w_issue      = !w_is_delay;
            w_delay_load = w_is_delay && !w_delay_zero;
         end
         S_WAIT_ACK: begin
            w_ack   = i2c.done;
            w_retry = i2c.done && i2c.nack && w_retry_left;
            w_fail  = i2c.done && i2c.nack && !w_retry_left;
         end
         S_RETRY:    w_reissue    = 1'b1;
         S_DELAY:    w_delay_dec  = 1'b1;
         S_NEXT:     w_index_inc  = 1'b1;
         S_DONE:     w_finish_ok  = 1'b1;
         S_ERROR:    w_finish_err = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx       <= '0;
         r_ent_addr  <= '0;
         r_ent_data  <= '0;
         r_dly_cnt   <= '0;
         r_rty_cnt   <= '0;
         r_profile   <= '0;
         r_req       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_err_index <= '0;
      end else begin
         if (w_accept) begin
            r_profile <= profile_sel;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b1;
         end
         if (w_load_entry) begin
            {r_ent_addr, r_ent_data} <= lut_data;
         end
         if (w_issue) begin
            r_addr    <= r_ent_addr;
            r_wdata   <= r_ent_data;
            r_req     <= 1'b1;
            r_rty_cnt <= '0;
         end
         if (w_delay_load) begin
            r_dly_cnt <= DLY_W'(r_ent_data) * c_ms_cyc;
         end
         if (w_delay_dec) begin
            r_dly_cnt <= r_dly_cnt - DLY_W'(1);
         end
         if (w_ack) begin
            r_req <= 1'b0;
         end
         if (w_retry) begin
            r_rty_cnt <= r_rty_cnt + RTY_W'(1);
         end
         if (w_fail) begin
            r_err_index <= r_idx[IDX_W-1:0];
         end
         // Address/data registers are untouched, so the retry repeats the same entry.
         if (w_reissue) begin
            r_req <= 1'b1;
         end
         if (w_index_inc) begin
            r_idx <= r_idx + (IDX_W+1)'(1);
         end
         if (w_finish_ok) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
         end
         if (w_finish_err) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
         end
      end
   end

   assign lut_profile = r_profile;
   assign lut_index   = r_idx[IDX_W-1:0];
   assign i2c.req     = r_req;
   assign i2c.addr    = r_addr;
   assign i2c.wdata   = r_wdata;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;
   assign err_index   = r_err_index;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_cfg_sequencer                                         |
// | Description : Directed self-checking bench for i2c_cfg_sequencer with a    |
// |               four-bank LUT model and an I2C slave model that completes    |
// |               each request five cycles after it appears.                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_i2c_cfg_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  profile_sel;
   logic [1:0]  lut_profile;
   logic [8:0]  lut_index;
   logic [23:0] lut_data;
   logic [9:0]  lut_size;
   logic        busy;
   logic        done;
   logic        error;
   logic [8:0]  err_index;

   i2c_cfg_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   i2c_cfg_sequencer #(
      .ADDR_W(16), .DATA_W(8), .IDX_W(9), .PROF_W(2),
      .CLK_FREQ(1000), .RETRY_MAX(3), .DELAY_ADDR(16'hFFFF)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .profile_sel(profile_sel),
      .lut_profile(lut_profile), .lut_index(lut_index),
      .lut_data(lut_data), .lut_size(lut_size),
      .i2c(bus),
      .busy(busy), .done(done), .error(error), .err_index(err_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- LUT model
   logic [23:0] lut_mem [0:3][0:7];
   logic [9:0]  size_tab [0:3];

   assign lut_data = lut_mem[lut_profile][lut_index[2:0]];
   assign lut_size = size_tab[lut_profile];

   // ---------------------------------------------------------------- I2C model
   logic [15:0] log_addr [0:31];
   logic [7:0]  log_data [0:31];
   int          log_cyc  [0:31];
   int          done_cyc [0:31];
   int          nlog  = 0;
   int          ndone = 0;
   int          m_cnt = 0;
   logic        m_busy = 1'b0;
   logic [15:0] nack_addr = 16'h0000;
   int          nack_left = 0;

   always @(negedge clk) begin
      if (rst) begin
         m_busy    = 1'b0;
         m_cnt     = 0;
         bus.done  = 1'b0;
         bus.nack  = 1'b0;
      end else if (bus.done) begin
         bus.done = 1'b0;
         bus.nack = 1'b0;
      end else if (!m_busy && bus.req) begin
         m_busy = 1'b1;
         m_cnt  = 0;
         if (nlog < 32) begin
            log_addr[nlog] = bus.addr;
            log_data[nlog] = bus.wdata;
            log_cyc[nlog]  = cyc;
            nlog++;
         end
      end else if (m_busy) begin
         m_cnt++;
         if (m_cnt == 5) begin
            bus.done = 1'b1;
            if (bus.addr == nack_addr && nack_left > 0) begin
               bus.nack = 1'b1;
               nack_left--;
            end
            m_busy = 1'b0;
            if (ndone < 32) begin
               done_cyc[ndone] = cyc;
               ndone++;
            end
         end
      end
   end

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_errors = 0;
   int start_cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      nlog  = 0;
      ndone = 0;
   endtask

   task automatic pulse_start(input logic [1:0] p);
      profile_sel = p;
      start       = 1'b1;
      @(negedge clk);
      start_cyc   = cyc;
      start       = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (!busy) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      check(tag, ok, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; profile_sel = 2'd0;
      for (int p = 0; p < 4; p++)
         for (int e = 0; e < 8; e++) lut_mem[p][e] = 24'h0;
      // bank 0: plain three-write table
      lut_mem[0][0] = {16'h0103, 8'h01};
      lut_mem[0][1] = {16'h0100, 8'h00};
      lut_mem[0][2] = {16'h3039, 8'hd3};
      size_tab[0]   = 10'd3;
      // bank 1: empty profile
      size_tab[1]   = 10'd0;
      // bank 2: 10 ms delay and zero delay interleaved with writes
      lut_mem[2][0] = {16'h0103, 8'h01};
      lut_mem[2][1] = {16'hFFFF, 8'h0A};
      lut_mem[2][2] = {16'h0100, 8'h00};
      lut_mem[2][3] = {16'hFFFF, 8'h00};
      lut_mem[2][4] = {16'h3039, 8'hd3};
      size_tab[2]   = 10'd5;
      // bank 3: NACK targets
      lut_mem[3][0] = {16'h1000, 8'h11};
      lut_mem[3][1] = {16'h1001, 8'h22};
      lut_mem[3][2] = {16'h1002, 8'h33};
      lut_mem[3][3] = {16'h1003, 8'h44};
      size_tab[3]   = 10'd4;

      repeat (3) @(negedge clk);
      check("rst_req",    bus.req,   1'b0);
      check("rst_busy",   busy,      1'b0);
      check("rst_done",   done,      1'b0);
      check("rst_error",  error,     1'b0);
      check("rst_index",  lut_index, 9'd0);
      check("rst_eidx",   err_index, 9'd0);
      rst = 1'b0;
      @(negedge clk);

      // ---- three-write table
      clear_log();
      pulse_start(2'd0);
      wait_idle("t1_timeout", 200);
      check("t1_nwrites", nlog, 3);
      check("t1_a0", log_addr[0], 16'h0103);
      check("t1_d0", log_data[0], 8'h01);
      check("t1_a1", log_addr[1], 16'h0100);
      check("t1_d1", log_data[1], 8'h00);
      check("t1_a2", log_addr[2], 16'h3039);
      check("t1_d2", log_data[2], 8'hd3);
      check("t1_req_lat", log_cyc[0] - start_cyc, 2);
      check("t1_gap", log_cyc[1] - done_cyc[0], 4);
      check("t1_done",  done,  1'b1);
      check("t1_error", error, 1'b0);
      check("t1_index", lut_index, 9'd3);

      // ---- delay entries: 10 ms then 0 ms
      clear_log();
      pulse_start(2'd2);
      wait_idle("t2_timeout", 300);
      check("t2_nwrites", nlog, 3);
      check("t2_a2", log_addr[2], 16'h3039);
      check("t2_gap_10ms", log_cyc[1] - done_cyc[0], 17);
      check("t2_gap_0ms",  log_cyc[2] - done_cyc[1], 7);
      check("t2_done", done, 1'b1);

      // ---- permanent NACK on entry 2
      clear_log();
      nack_addr = 16'h1002; nack_left = 100;
      pulse_start(2'd3);
      wait_idle("t3_timeout", 300);
      check("t3_nwrites", nlog, 6);
      check("t3_last_addr", log_addr[5], 16'h1002);
      check("t3_error", error, 1'b1);
      check("t3_done",  done,  1'b0);
      check("t3_eidx",  err_index, 9'd2);
      repeat (10) @(negedge clk);
      check("t3_no_more", nlog, 6);

      // ---- two NACKs on entry 1 then ACK; stray start while busy
      clear_log();
      nack_addr = 16'h1001; nack_left = 2;
      pulse_start(2'd3);
      repeat (3) @(negedge clk);
      profile_sel = 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t4_profile_held", lut_profile, 2'd3);
      wait_idle("t4_timeout", 300);
      check("t4_nwrites", nlog, 6);
      check("t4_a1", log_addr[1], 16'h1001);
      check("t4_a3", log_addr[3], 16'h1001);
      check("t4_d3", log_data[3], 8'h22);
      check("t4_a4", log_addr[4], 16'h1002);
      check("t4_a5", log_addr[5], 16'h1003);
      check("t4_done",  done,  1'b1);
      check("t4_error", error, 1'b0);

      // ---- empty profile
      clear_log();
      pulse_start(2'd1);
      check("t5_busy_s0", busy, 1'b1);
      @(negedge clk);
      check("t5_done_s1", done, 1'b0);
      @(negedge clk);
      check("t5_done_s2", done, 1'b1);
      check("t5_busy_s2", busy, 1'b0);
      check("t5_nwrites", nlog, 0);

      // ---- asynchronous reset mid-request, then replay
      clear_log();
      pulse_start(2'd0);
      begin
         int ok = 0;
         for (int i = 0; i < 100; i++) begin
            if (nlog == 2 && bus.req) begin
               ok = 1;
               break;
            end
            @(negedge clk);
         end
         check("t6_reach_w1", ok, 1);
      end
      #2 rst = 1'b1;
      #1;
      check("t6_req",   bus.req,   1'b0);
      check("t6_busy",  busy,      1'b0);
      check("t6_index", lut_index, 9'd0);
      check("t6_addr",  bus.addr,  16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      clear_log();
      pulse_start(2'd0);
      wait_idle("t6_timeout", 200);
      check("t6_nwrites", nlog, 3);
      check("t6_a0", log_addr[0], 16'h0103);
      check("t6_done", done, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
